// File: rtl/sokoban_move_engine.sv
// Sokoban move engine: reads neighbour tiles, applies push/walk rules,
// writes the map back and tracks player position, score and boxes.
module sokoban_move_engine #(
  parameter int MAP_WIDTH  = 20,
  parameter int MAP_HEIGHT = 15,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        load_x,
  input  logic [7:0]        load_y,
  input  logic [7:0]        load_boxes,
  input  logic [ADDR_W-1:0] map_base,
  input  logic              move_valid,
  input  logic [1:0]        move_dir,
  output logic              busy,
  output logic              move_done,
  output logic [1:0]        move_result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        player_x,
  output logic [7:0]        player_y,
  output logic [7:0]        score,
  output logic [7:0]        remaining_boxes,
  output logic              solved
);

  typedef enum logic [2:0] {
    IDLE, RD1, EV1, RD2, EV2, WR2, WR1, DONE
  } state_t;

  localparam logic [7:0] T_BOX   = 8'd1;
  localparam logic [7:0] T_READY = 8'd2;
  localparam logic [7:0] T_TGT   = 8'd3;
  localparam logic [7:0] T_EMPTY = 8'd6;

  localparam logic [1:0] R_BLOCK = 2'd0;
  localparam logic [1:0] R_WALK  = 2'd1;
  localparam logic [1:0] R_PUSH  = 2'd2;

  localparam logic [7:0] W8 = 8'(MAP_WIDTH);
  localparam logic [7:0] H8 = 8'(MAP_HEIGHT);

  state_t state_q, state_d;

  logic [7:0] x1_q, y1_q, x2_q, y2_q;
  logic [7:0] tile1_q, tile2_q;
  logic [7:0] dx, dy;
  logic [7:0] score_inc;
  logic [7:0] rb_next;
  logic       oob1, oob2;
  logic       rd_floor, rd_box;
  logic [ADDR_W-1:0] addr1, addr2;

  // Direction decode, bounds, tile classes and derived addresses.
  always_comb begin
    dx = 8'd0;
    dy = 8'd0;
    unique case (move_dir)
      2'd0: dy = 8'hff;
      2'd1: dy = 8'd1;
      2'd2: dx = 8'hff;
      2'd3: dx = 8'd1;
    endcase
    oob1 = (x1_q >= W8) || (y1_q >= H8);
    oob2 = (x2_q >= W8) || (y2_q >= H8);
    rd_floor = (mem_rdata == T_TGT) || (mem_rdata == T_EMPTY);
    rd_box = (mem_rdata == T_BOX) || (mem_rdata == T_READY);
    addr1 = map_base + ADDR_W'(y1_q) * ADDR_W'(MAP_WIDTH)
          + ADDR_W'(x1_q);
    addr2 = map_base + ADDR_W'(y2_q) * ADDR_W'(MAP_WIDTH)
          + ADDR_W'(x2_q);
    score_inc = (score == 8'hff) ? 8'hff : score + 8'd1;
    rb_next = remaining_boxes;
    if (tile1_q == T_BOX && tile2_q == T_TGT)
      rb_next = (remaining_boxes == 8'd0) ? 8'd0
              : remaining_boxes - 8'd1;
    else if (tile1_q == T_READY && tile2_q == T_EMPTY)
      rb_next = (remaining_boxes == 8'hff) ? 8'hff
              : remaining_boxes + 8'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory-port / handshake outputs.
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    move_done = 1'b0;
    busy      = (state_q != IDLE) && !rst;
    if (rst || load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (move_valid) state_d = RD1;
        RD1: begin
          if (oob1) begin
            state_d = DONE;
          end else begin
            mem_addr = addr1;
            state_d  = EV1;
          end
        end
        EV1: state_d = rd_box ? RD2 : DONE;
        RD2: begin
          if (oob2) begin
            state_d = DONE;
          end else begin
            mem_addr = addr2;
            state_d  = EV2;
          end
        end
        EV2: state_d = rd_floor ? WR2 : DONE;
        WR2: begin
          mem_addr  = addr2;
          mem_we    = 1'b1;
          mem_wdata = (tile2_q == T_TGT) ? T_READY : T_BOX;
          state_d   = WR1;
        end
        WR1: begin
          mem_addr  = addr1;
          mem_we    = 1'b1;
          mem_wdata = (tile1_q == T_READY) ? T_TGT : T_EMPTY;
          state_d   = DONE;
        end
        DONE: begin
          move_done = 1'b1;
          state_d   = IDLE;
        end
      endcase
    end
  end

  // Game state: destinations, sampled tiles, player, score, boxes.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= 8'd0;
      y1_q <= 8'd0;
      x2_q <= 8'd0;
      y2_q <= 8'd0;
      tile1_q <= 8'd0;
      tile2_q <= 8'd0;
      player_x <= 8'd0;
      player_y <= 8'd0;
      score <= 8'd0;
      remaining_boxes <= 8'd0;
      solved <= 1'b0;
      move_result <= R_BLOCK;
    end else if (load) begin
      player_x <= load_x;
      player_y <= load_y;
      remaining_boxes <= load_boxes;
      solved <= (load_boxes == 8'd0);
      score <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            x1_q <= player_x + dx;
            y1_q <= player_y + dy;
            x2_q <= player_x + {dx[6:0], 1'b0};
            y2_q <= player_y + {dy[6:0], 1'b0};
          end
        end
        RD1: if (oob1) move_result <= R_BLOCK;
        EV1: begin
          tile1_q <= mem_rdata;
          if (rd_floor) begin
            player_x <= x1_q;
            player_y <= y1_q;
            score <= score_inc;
            move_result <= R_WALK;
          end else if (!rd_box) begin
            move_result <= R_BLOCK;
          end
        end
        RD2: if (oob2) move_result <= R_BLOCK;
        EV2: begin
          tile2_q <= mem_rdata;
          if (!rd_floor) move_result <= R_BLOCK;
        end
        WR1: begin
          player_x <= x1_q;
          player_y <= y1_q;
          score <= score_inc;
          remaining_boxes <= rb_next;
          solved <= (rb_next == 8'd0);
          move_result <= R_PUSH;
        end
        default: ;
      endcase
    end
  end

endmodule
